// File: rtl/instruction_fetch_memory.sv
// Instruction memory with a LOAD phase for program download and a RUN phase
// serving 1-cycle-latency fetches over a valid/ready request/response pair.
module instruction_fetch_memory #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        load_err,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_fault,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [31:0] mem [DEPTH];

  logic        in_load;
  logic        in_run;
  logic        ld_ok;
  logic        mem_we;
  logic        req_mis;
  logic        req_oor;
  logic        accept;

  logic        load_err_q, load_err_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [1:0]  resp_fault_q, resp_fault_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_LOAD;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_LOAD && load_done) state_d = S_RUN;
  end

  always_comb begin
    in_load   = (state_q == S_LOAD);
    in_run    = (state_q == S_RUN);
    req_ready = in_run && (!resp_valid_q || resp_ready);
  end

  // DEPTH is a power of two, so "in range" means the bits above the index are zero
  assign ld_ok   = (load_addr[1:0] == 2'b00) && (load_addr[31:AW+2] == '0);
  assign mem_we  = in_load && load_we && ld_ok;
  assign req_mis = (req_addr[1:0] != 2'b00);
  assign req_oor = (req_addr[31:AW+2] != '0);
  assign accept  = req_valid && req_ready;

  always_ff @(posedge clock) begin
    if (mem_we) mem[load_addr[AW+1:2]] <= load_data;
  end

  always_comb begin
    load_err_d    = load_err_q | (in_load && load_we && !ld_ok);
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_fault_d  = resp_fault_q;
    fetch_count_d = fetch_count_q;
    if (accept) begin
      resp_valid_d  = 1'b1;
      fetch_count_d = fetch_count_q + 16'd1;
      if (req_mis) begin
        resp_fault_d = 2'b01;
        resp_data_d  = NOP_WORD;
      end else if (req_oor) begin
        resp_fault_d = 2'b10;
        resp_data_d  = NOP_WORD;
      end else begin
        resp_fault_d = 2'b00;
        resp_data_d  = mem[req_addr[AW+1:2]];
      end
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_err_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= 32'h0;
      resp_fault_q  <= 2'b00;
      fetch_count_q <= 16'h0;
    end else begin
      load_err_q    <= load_err_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_fault_q  <= resp_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign load_err    = load_err_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_fault  = resp_fault_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Randomized bench for instruction_fetch_memory against a cycle-level
// behavioural model of the load/run memory and its fetch response.
module tb_instruction_fetch_memory;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        load_err;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_fault;
  logic [15:0] fetch_count;

  instruction_fetch_memory #(
    .DEPTH(DEPTH),
    .NOP_WORD(NOP)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .load_we(load_we),
    .load_addr(load_addr),
    .load_data(load_data),
    .load_done(load_done),
    .load_err(load_err),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_fault(resp_fault),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_run;
  bit          m_valid;
  logic [31:0] m_data;
  logic [1:0]  m_fault;
  logic [15:0] m_count;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_fault = 2'b00;
    m_count = 16'h0;
    m_err   = 1'b0;
  endtask

  task automatic check_outputs();
    check("resp_valid", 32'(resp_valid), 32'(m_valid));
    check("fetch_count", 32'(fetch_count), 32'(m_count));
    check("load_err", 32'(load_err), 32'(m_err));
    if (m_valid) begin
      check("resp_fault", 32'(resp_fault), 32'(m_fault));
      if (m_fault != 2'b00 || m_known[m_data[31:0] == m_data ? 0 : 0] || 1'b1)
        ;
    end
  endtask

  bit m_data_known;

  // One clock cycle: drive inputs, check the combinational ready, step the model
  task automatic cyc(input bit we, input logic [31:0] la,
                     input logic [31:0] ld, input bit done, input bit rv,
                     input logic [31:0] ra, input bit rr);
    bit exp_rdy;
    bit acc;
    load_we    = we;
    load_addr  = la;
    load_data  = ld;
    load_done  = done;
    req_valid  = rv;
    req_addr   = ra;
    resp_ready = rr;
    #1;
    exp_rdy = m_run && (!m_valid || rr);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    acc = rv && exp_rdy;
    if (!m_run) begin
      if (we) begin
        if (la[1:0] == 2'b00 && (la >> 2) < DEPTH) begin
          m_mem[la >> 2]   = ld;
          m_known[la >> 2] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (done) m_run = 1'b1;
    end
    if (acc) begin
      m_valid = 1'b1;
      m_count = m_count + 16'd1;
      if (ra[1:0] != 2'b00) begin
        m_fault = 2'b01;
        m_data  = NOP;
        m_data_known = 1'b1;
      end else if ((ra >> 2) >= DEPTH) begin
        m_fault = 2'b10;
        m_data  = NOP;
        m_data_known = 1'b1;
      end else begin
        m_fault = 2'b00;
        m_data  = m_mem[ra >> 2];
        m_data_known = m_known[ra >> 2];
      end
    end else if (rr) begin
      m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
    check_outputs();
    if (m_valid && m_data_known) check("resp_data", resp_data, m_data);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic fetch(input logic [31:0] ra);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, ra, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (r == 7)
      return (32'($urandom_range(0, DEPTH + 8)) << 2) |
             32'($urandom_range(1, 3));
    if (r == 8) return (32'(DEPTH) + 32'($urandom_range(0, 500))) << 2;
    return ($urandom() | 32'h8000_0000) & 32'hFFFF_FFFC;
  endfunction

  initial begin
    int guard;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_data_known = 1'b0;
    model_reset();
    reset_n    = 1'b0;
    load_we    = 1'b0;
    load_addr  = 32'h0;
    load_data  = 32'h0;
    load_done  = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    resp_ready = 1'b1;
    #3;
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_fault", 32'(resp_fault), 32'h0);
    check("rst_fetch_count", 32'(fetch_count), 32'h0);
    check("rst_load_err", 32'(load_err), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Fetch attempts while loading are refused
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b1);
    cyc(1'b1, 32'h0, 32'h0274_4820, 1'b0, 1'b1, 32'h0, 1'b1);
    cyc(1'b1, 32'h4, 32'h0257_9822, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h2, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b0);
    check("misaligned_load_err", 32'(load_err), 32'h1);
    cyc(1'b1, 32'(DEPTH) << 2, 32'hEEEE_EEEE, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 2; i < DEPTH - 1; i++)
      cyc(1'b1, 32'(i) << 2, $urandom(), 1'b0, 1'b0, 32'h0, 1'b1);
    // Final word is written in the same cycle as load_done
    cyc(1'b1, 32'(DEPTH - 1) << 2, $urandom(), 1'b1, 1'b0, 32'h0, 1'b1);

    fetch(32'h4);
    check("scn_data_0x4", resp_data, 32'h0257_9822);
    fetch(32'h0);
    fetch(32'h26);
    check("scn_fault_mis", 32'(resp_fault), 32'h1);
    fetch(32'(DEPTH) << 2);
    check("scn_fault_oor", 32'(resp_fault), 32'h2);
    fetch(32'(DEPTH - 1) << 2);
    fetch(32'h0);
    fetch(32'(DEPTH) << 2 | 32'h1);

    // Backpressure: three stalled cycles, then stream
    fetch(32'h8);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC, 1'b0);
    for (int i = 0; i < 4; i++)
      fetch(32'(i) << 2);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1) == 1, rand_addr(), $urandom(),
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
          rand_addr(), $urandom_range(0, 3) != 0);

    // Stream until the fetch counter wraps to zero
    guard = 0;
    do begin
      fetch(rand_addr());
      guard++;
    end while (m_count != 16'h0 && guard < 70000);
    check("wrap_count", 32'(fetch_count), 32'h0);

    // Reset while a response is pending drops it at once
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0);
    check("pend_valid", 32'(resp_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_drop_valid", 32'(resp_valid), 32'h0);
    check("rst_drop_ready", 32'(req_ready), 32'h0);
    check("rst_drop_count", 32'(fetch_count), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    req_valid = 1'b0;

    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    // Loads in RUN are ignored and never raise load_err
    cyc(1'b1, 32'h2, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b1);
    check("run_load_err", 32'(load_err), 32'h0);
    fetch(32'h0);
    check("post_rst_data", resp_data, 32'h0274_4820);
    fetch(32'h4);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_memory.md
INSTRUCTION_FETCH_MEMORY -- requirements
Module: instruction_fetch_memory

Interface
REQ-001 Parameter DEPTH, default 64, meaning: number of 32-bit instruction words stored, a power of two from 4 to 4096.
REQ-002 Parameter NOP_WORD, default 32'h00000000, meaning: data returned on a faulting fetch.
REQ-003 Parameter AW, default clog2(DEPTH), meaning: word-index width, derived and not overridden.
REQ-004 clock  input  1  rising-edge clock; the block uses one clock.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 load_we  input  1  program-load write strobe.
REQ-007 load_addr  input  32  byte address of the word being loaded.
REQ-008 load_data  input  32  instruction word being loaded.
REQ-009 load_done  input  1  one-cycle pulse ending program load.
REQ-010 load_err  output  1  sticky flag: a load was aligned-invalid or out of range.
REQ-011 req_valid  input  1  fetch request valid.
REQ-012 req_ready  output  1  fetch request accepted this cycle when high with req_valid.
REQ-013 req_addr  input  32  fetch byte address (PC).
REQ-014 resp_valid  output  1  response holds valid data.
REQ-015 resp_ready  input  1  consumer takes the response.
REQ-016 resp_data  output  32  fetched instruction.
REQ-017 resp_fault  output  2  00 ok, 01 misaligned, 10 out of range.
REQ-018 fetch_count  output  16  number of accepted fetches.

Function
REQ-019 The FSM SHALL have two states, LOAD and RUN, entering LOAD on reset.
REQ-020 In LOAD, load_we with load_addr[1:0]==0 and load_addr[31:2]<DEPTH SHALL write load_data to word load_addr[AW+1:2] at the clock edge.
REQ-021 In LOAD, load_we with a misaligned or out-of-range address SHALL leave memory unchanged and set load_err.
REQ-022 load_done in LOAD SHALL move the FSM to RUN on the next edge; a load_we in the same cycle SHALL still be performed.
REQ-023 In RUN, load_we and load_done SHALL be ignored without setting load_err.
REQ-024 req_ready SHALL equal (state==RUN) and (!resp_valid or resp_ready), combinationally.
REQ-025 A fetch is accepted on an edge where req_valid and req_ready are both high; its response SHALL appear on the next cycle, a latency of 1.
REQ-026 An accepted fetch with req_addr[1:0]!=0 SHALL respond with resp_fault=01 and resp_data=NOP_WORD.
REQ-027 An aligned fetch with req_addr[31:2]>=DEPTH SHALL respond with resp_fault=10 and resp_data=NOP_WORD; a misaligned fault SHALL take priority over an out-of-range fault.
REQ-028 Otherwise the response SHALL be resp_fault=00 and resp_data equal to the stored word.
REQ-029 While resp_valid=1 and resp_ready=0, resp_data and resp_fault SHALL hold stable and no fetch SHALL be accepted.
REQ-030 When resp_ready=1 and no new fetch is accepted, resp_valid SHALL drop on the next edge.
REQ-031 When resp_ready=1 and a new fetch is accepted, responses SHALL stream back-to-back, one per cycle.
REQ-032 fetch_count SHALL increment by 1 per accepted fetch, faults included, and wrap from 16'hFFFF to 0.
REQ-033 A word never loaded SHALL read as an unspecified value with resp_fault=00.

Reset
REQ-034 On reset, outputs SHALL be: state=LOAD, resp_valid=0, resp_data=0, resp_fault=00, fetch_count=0, load_err=0, req_ready=0.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 A reset asserted while a response is pending SHALL discard that response immediately.
REQ-037 After reset the memory SHALL require a new load_done before fetches are accepted, with previously loaded words still readable.

Verification
REQ-038 Scenario: load 32'h02744820 at 0x0 and 32'h0257982 2 at 0x4, pulse load_done, fetch 0x4 -> next cycle resp_valid=1, resp_data=32'h02579822, resp_fault=00.
REQ-039 Scenario: fetch 0x26 in RUN -> resp_fault=01, resp_data=NOP_WORD; fetch byte address 4*DEPTH -> resp_fault=10.
REQ-040 Scenario: hold resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, resp_data stable, fetch_count unchanged; release -> streaming at 1 word/cycle.
REQ-041 Scenario: in LOAD, load_we at 0x2 -> load_err=1 and memory unchanged; req_valid in LOAD -> req_ready=0.
REQ-042 Scenario: 65536 accepted fetches -> fetch_count wraps to 0.
REQ-043 Scenario: assert reset_n=0 with resp_valid=1 -> resp_valid=0 at once; after a new load_done, a fetch of 0x0 returns the previously loaded 32'h02744820.
